// File: rtl/conv_result_buf_if.sv
// Handshake bundle for conv_result_buf: partial-sum input stream, result stream and status.
// The block itself connects through the slave modport.
interface conv_result_buf_if #(
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic                        relu_en;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_WIDTH-1:0]        count;
  logic                        sat_flag;

  modport master (
    output in_data, in_valid, in_last, relu_en, out_ready,
    input  in_ready, out_data, out_valid, count, sat_flag
  );

  modport slave (
    input  in_data, in_valid, in_last, relu_en, out_ready,
    output in_ready, out_data, out_valid, count, sat_flag
  );
endinterface

// File: rtl/conv_result_buf.sv
// Accumulates signed partial sums per output pixel, applies optional ReLU and saturation,
// and queues the results in a small first-word-fall-through FIFO.
module conv_result_buf #(
  parameter int IN_WIDTH  = 20,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input logic             clk,
  input logic             rst,
  conv_result_buf_if.slave bus
);
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic [PTR_WIDTH-1:0]        wr_ptr_reg;
  logic [PTR_WIDTH-1:0]        rd_ptr_reg;
  logic [CNT_WIDTH-1:0]        count_reg;
  logic                        sat_flag_reg;
  logic [OUT_WIDTH-1:0]        mem [DEPTH];

  logic signed [IN_WIDTH-1:0]  in_data_s;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] relu_val;
  logic [OUT_WIDTH-1:0]        result_next;
  logic                        clip_next;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        not_empty;

  assign in_data_s = bus.in_data;
  assign in_ext    = ACC_WIDTH'(in_data_s);
  assign sum       = acc_reg + in_ext;

  // Reset forces the idle output view even before the clearing edge has happened.
  assign not_empty    = (count_reg != '0);
  assign bus.in_ready = !rst || (count_reg < CNT_WIDTH'(DEPTH));
  assign bus.out_valid = rst && not_empty;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr_reg] : '0;
  assign bus.count     = count_reg;
  assign bus.sat_flag  = sat_flag_reg;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && bus.in_last;
  assign pop    = bus.out_valid && bus.out_ready;

  // ReLU is applied before clipping, so a rectified value can only ever hit the upper bound.
  always_comb begin
    relu_val    = sum;
    result_next = sum[OUT_WIDTH-1:0];
    clip_next   = 1'b0;
    if (bus.relu_en && sum[ACC_WIDTH-1]) begin
      relu_val = '0;
    end
    if (relu_val > SAT_MAX) begin
      result_next = SAT_MAX[OUT_WIDTH-1:0];
      clip_next   = 1'b1;
    end else if (relu_val < SAT_MIN) begin
      result_next = SAT_MIN[OUT_WIDTH-1:0];
      clip_next   = 1'b1;
    end else begin
      result_next = relu_val[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= result_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      sat_flag_reg <= 1'b0;
    end else begin
      if (accept) begin
        acc_reg <= bus.in_last ? '0 : sum;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (clip_next) begin
          sat_flag_reg <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Push is blocked when full and pop when empty, so count stays within 0..DEPTH.
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_result_buf.sv
// Scoreboard bench for conv_result_buf: the driver feeds a plain-arithmetic reference model,
// and a monitor compares every FIFO head the block presents against the expected queue.
module tb_conv_result_buf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_result_buf_if #(.IN_WIDTH(20), .OUT_WIDTH(16), .DEPTH(4)) bus ();

  conv_result_buf #(
    .IN_WIDTH (20),
    .ACC_WIDTH(24),
    .OUT_WIDTH(16),
    .DEPTH    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     checks = 0;
  int     passes = 0;
  longint model_acc = 0;
  longint exp_q[$];
  bit     exp_sat = 1'b0;
  bit     rand_mode = 1'b0;
  bit     ready_force = 1'b1;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic longint wrap24(input longint v);
    longint m;
    m = v & 64'h0000_0000_00FF_FFFF;
    if (m >= 64'sd8388608) m = m - 64'sd16777216;
    return m;
  endfunction

  // Reference: mathematical sum wrapped to 24 bits, rectify, then clamp to int16.
  task automatic model_accept(input longint d, input bit last, input bit relu);
    longint s;
    longint v;
    s = wrap24(model_acc + d);
    if (!last) begin
      model_acc = s;
    end else begin
      v = s;
      if (relu && v < 0) v = 0;
      if (v > 32767) begin
        v = 32767;
        exp_sat = 1'b1;
      end else if (v < -32768) begin
        v = -32768;
        exp_sat = 1'b1;
      end
      exp_q.push_back(v);
      model_acc = 0;
      $display("push expect %0d (relu=%0b)", v, relu);
    end
  endtask

  function automatic longint out_s();
    return longint'(bus.out_data);
  endfunction

  // Called aligned one step after a rising edge; returns aligned the same way.
  task automatic send_beat(input longint d, input bit last, input bit relu);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    bus.in_data  = d[19:0];
    bus.in_last  = last;
    bus.relu_en  = relu;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(d, last, relu);
        done = 1'b1;
      end else if (++waited > 200) begin
        checks++;
        $display("FAIL accept_timeout: beat %0d not accepted within 200 cycles, required acceptance", d);
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results left, required 0", exp_q.size());
      exp_q.delete();
    end
    align();
    @(negedge clk);
    check("drain_count", longint'(bus.count), 0);
    align();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    exp_q.delete();
    model_acc = 0;
    exp_sat   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // out_ready driver: random backpressure or a forced level.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: every presented head must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_valid: out_valid=1 data %0d, required no result", out_s());
        end else begin
          check(bus.out_ready ? "pop_data" : "held_data", out_s(), exp_q[0]);
          if (bus.out_ready) begin
            $display("pop %0d", out_s());
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_data_zero", out_s(), 0);
      end
    end
  end

  initial begin
    logic signed [19:0] r20;
    longint d;
    bit     last;

    rst          = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.relu_en  = 1'b0;

    // Reset state, including the in-reset output view.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_out_data", out_s(), 0);
    align();
    rst = 1'b1;
    @(negedge clk);
    check("rst_count", longint'(bus.count), 0);
    check("rst_sat_flag", longint'(bus.sat_flag), 0);
    check("rst_in_ready_after", longint'(bus.in_ready), 1);
    align();

    // Basic accumulation with latency-1 visibility.
    ready_force = 1'b1;
    align();
    align();
    send_beat(10, 1'b0, 1'b0);
    send_beat(-3, 1'b0, 1'b0);
    send_beat(5, 1'b1, 1'b0);
    @(negedge clk);
    check("lat1_valid", longint'(bus.out_valid), 1);
    check("sum_12", out_s(), 12);
    check("sum_sat_flag", longint'(bus.sat_flag), 0);
    align();

    // ReLU on and off for the same negative pixel.
    send_beat(-7, 1'b0, 1'b0);
    send_beat(-1, 1'b1, 1'b1);
    @(negedge clk);
    check("relu_zero", out_s(), 0);
    align();
    send_beat(-7, 1'b0, 1'b1);
    send_beat(-1, 1'b1, 1'b0);
    @(negedge clk);
    check("no_relu_neg8", out_s(), -8);
    align();

    // Saturation both ways.
    send_beat(20000, 1'b0, 1'b0);
    send_beat(20000, 1'b1, 1'b0);
    @(negedge clk);
    check("sat_hi", out_s(), 32767);
    check("sat_flag_set", longint'(bus.sat_flag), 1);
    align();
    send_beat(-20000, 1'b0, 1'b0);
    send_beat(-20000, 1'b1, 1'b0);
    @(negedge clk);
    check("sat_lo", out_s(), -32768);
    align();
    drain();

    // Fill with backpressure, hold off the fifth beat, then release.
    ready_force = 1'b0;
    align();
    align();
    for (int k = 1; k <= 4; k++) send_beat(k, 1'b1, 1'b0);
    @(negedge clk);
    check("full_count", longint'(bus.count), 4);
    check("full_in_ready", longint'(bus.in_ready), 0);
    align();
    fork
      send_beat(5, 1'b1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("held_count", longint'(bus.count), 4);
        check("held_in_ready", longint'(bus.in_ready), 0);
        ready_force = 1'b1;
      end
    join
    drain();

    // Reset mid-accumulation discards the partial sum.
    ready_force = 1'b0;
    align();
    align();
    send_beat(100, 1'b0, 1'b0);
    do_reset(1);
    send_beat(7, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_mid_data", out_s(), 7);
    check("rst_mid_count", longint'(bus.count), 1);
    check("rst_mid_sat", longint'(bus.sat_flag), 0);
    ready_force = 1'b1;
    align();
    drain();

    // Randomized beats with random backpressure and idle gaps.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r20 = 20'($urandom);
        d   = r20;
      end else begin
        d = longint'($urandom_range(0, 4000)) - 2000;
      end
      last = ($urandom_range(0, 3) == 0);
      send_beat(d, last, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) align();
    end
    send_beat(0, 1'b1, 1'b0);
    rand_mode   = 1'b0;
    ready_force = 1'b1;
    align();
    drain();
    @(negedge clk);
    check("final_sat_flag", longint'(bus.sat_flag), longint'(exp_sat));
    check("final_out_valid", longint'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
